spectrum_writer: RTL and testbench
==================================

SPECTRUM_WRITER -- requirements
Module: spectrum_writer

Parameters
REQ-001 N_BINS, 512, number of bins per frame; bin index k runs 0..N_BINS-1.
REQ-002 IM_OFFSET, 1024, address offset of the imaginary half of the spectrum memory.
REQ-003 SHIFT, 6, arithmetic right shift applied to each input sample before saturation.

Interface
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 in_valid  in  1  input bin valid.
REQ-008 in_ready  out  1  writer can accept a bin.
REQ-009 in_re  in  16 signed  real part of bin k.
REQ-010 in_im  in  16 signed  imaginary part of bin k.
REQ-011 in_last  in  1  marks the final bin of a frame.
REQ-012 mem_addr  out  11  spectrum memory write address.
REQ-013 mem_wdata  out  10 signed  spectrum memory write data.
REQ-014 mem_we  out  1  spectrum memory write strobe.
REQ-015 find_enable  out  1  start request to the frequency finder.
REQ-016 find_done  in  1  finder completion pulse (did_find).
REQ-017 find_note  in  3  note index from the finder.
REQ-018 find_diff  in  10 signed  bin difference from the finder.
REQ-019 note_out  out  3  latched note.
REQ-020 diff_out  out  10 signed  latched difference.
REQ-021 result_valid  out  1  one-cycle pulse when note_out/diff_out update.
REQ-022 frame_err  out  1  sticky framing-error flag.

Function
REQ-023 FSM states: ACCEPT, WR_RE, WR_IM, START_FIND, WAIT_FIND.
REQ-024 in_ready SHALL be 1 only in ACCEPT; a transfer occurs when in_valid && in_ready.
- On transfer, latch in_re, in_im and in_last, then go to WR_RE.
REQ-025 WR_RE: mem_we=1, mem_addr=k, mem_wdata=sat10(in_re>>>SHIFT); next state WR_IM.
REQ-026 WR_IM: mem_we=1, mem_addr=k+IM_OFFSET, mem_wdata=sat10(in_im>>>SHIFT).
REQ-027 sat10 SHALL clamp to [-512, 511]; the shift is arithmetic (sign-preserving).
REQ-028 Maximum throughput is one bin per 3 cycles (ACCEPT, WR_RE, WR_IM).
REQ-029 After WR_IM with k<N_BINS-1 and latched in_last=0: increment k, return to ACCEPT.
REQ-030 After WR_IM with k=N_BINS-1 and latched in_last=1: reset k to 0, go to START_FIND.
REQ-031 Framing errors: latched in_last=1 with k<N_BINS-1, or k=N_BINS-1 with latched in_last=0.
- Action: set frame_err, reset k to 0, return to ACCEPT; no find is started.
- Bins already written remain in memory.
REQ-032 START_FIND: find_enable=1 for exactly one cycle; next state WAIT_FIND.
REQ-033 WAIT_FIND: in_ready=0 and mem_we=0 (memory owned by the reader) until find_done=1.
REQ-034 On find_done in WAIT_FIND: note_out<=find_note, diff_out<=find_diff, result_valid=1 for one cycle, return to ACCEPT.
REQ-035 find_done outside WAIT_FIND SHALL be ignored: no latch, no result_valid.
REQ-036 mem_we SHALL be 0 in every state other than WR_RE and WR_IM.
REQ-037 frame_err is cleared only by rst.

Reset
REQ-038 rst SHALL force, on the next edge and regardless of state:
- state=ACCEPT, k=0, in_ready=1;
- mem_we=0, mem_addr=0, mem_wdata=0;
- find_enable=0, note_out=0, diff_out=0, result_valid=0, frame_err=0.
REQ-039 Reset mid-frame or in WAIT_FIND SHALL abandon the frame; the first post-reset bin is written at address 0.

Verification
REQ-040 Full frame of 512 bins, re=k<<6, im=-(k<<6), last on bin 511.
- Required: mem[k]=k clamped to 511; mem[k+1024]=-k clamped to -512.
- Required: exactly one find_enable pulse, 1 cycle after the bin-511 WR_IM.
REQ-041 Saturation: re=32767 -> wdata 511; re=-32768 -> wdata -512; re=-1 -> wdata -1.
REQ-042 Result capture: in WAIT_FIND, drive find_done with note=3, diff=-4.
- Required: note_out=3, diff_out=-4, one-cycle result_valid, in_ready=1 the next cycle.
REQ-043 Early last on bin 10: frame_err=1, no find_enable pulse; the next bin writes address 0.
REQ-044 Missing last on bin 511: frame_err=1, no find_enable pulse, k returns to 0.
REQ-045 rst asserted at bin 200, then a full frame: writes start at address 0, one find_enable pulse, frame_err=0.

Source files
------------

// File: rtl/spectrum_writer.sv
// Spectrum writer: accepts one FFT bin at a time, writes its real and imaginary parts
// (scaled and saturated to 10 bits) into the spectrum memory, then hands off to the finder.
module spectrum_writer #(
  parameter int N_BINS    = 512,
  parameter int IM_OFFSET = 1024,
  parameter int SHIFT     = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] in_re,
  input  logic signed [15:0] in_im,
  input  logic               in_last,
  output logic [10:0]        mem_addr,
  output logic signed [9:0]  mem_wdata,
  output logic               mem_we,
  output logic               find_enable,
  input  logic               find_done,
  input  logic [2:0]         find_note,
  input  logic signed [9:0]  find_diff,
  output logic [2:0]         note_out,
  output logic signed [9:0]  diff_out,
  output logic               result_valid,
  output logic               frame_err
);

  localparam int K_W = $clog2(N_BINS);
  localparam logic [K_W-1:0] K_LAST = K_W'(N_BINS - 1);

  typedef enum logic [2:0] {ACCEPT, WR_RE, WR_IM, START_FIND, WAIT_FIND} state_t;

  state_t             state;
  logic [K_W-1:0]     k;
  logic signed [15:0] im_q;
  logic               last_q;

  function automatic logic signed [9:0] sat10(input logic signed [15:0] x);
    logic signed [15:0] s;
    s = x >>> SHIFT;
    if (s > 16'sd511)       return 10'sd511;
    else if (s < -16'sd512) return -10'sd512;
    else                    return s[9:0];
  endfunction

  // Outputs are registered for the state being entered, so the write strobe,
  // address and data are all valid for the whole WR_RE / WR_IM cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCEPT;
      k            <= '0;
      im_q         <= '0;
      last_q       <= 1'b0;
      in_ready     <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      find_enable  <= 1'b0;
      note_out     <= '0;
      diff_out     <= '0;
      result_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      find_enable  <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        ACCEPT: begin
          if (in_valid && in_ready) begin
            im_q      <= in_im;
            last_q    <= in_last;
            in_ready  <= 1'b0;
            mem_we    <= 1'b1;
            mem_addr  <= 11'(k);
            mem_wdata <= sat10(in_re);
            state     <= WR_RE;
          end
        end
        WR_RE: begin
          mem_addr  <= 11'(k) + 11'(IM_OFFSET);
          mem_wdata <= sat10(im_q);
          state     <= WR_IM;
        end
        WR_IM: begin
          mem_we <= 1'b0;
          if (last_q && k == K_LAST) begin
            k           <= '0;
            find_enable <= 1'b1;
            state       <= START_FIND;
          end else if (!last_q && k != K_LAST) begin
            k        <= k + K_W'(1);
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end else begin
            // Framing error: drop the frame, keep what was written, no find.
            frame_err <= 1'b1;
            k         <= '0;
            in_ready  <= 1'b1;
            state     <= ACCEPT;
          end
        end
        START_FIND: state <= WAIT_FIND;
        WAIT_FIND: begin
          if (find_done) begin
            note_out     <= find_note;
            diff_out     <= find_diff;
            result_valid <= 1'b1;
            in_ready     <= 1'b1;
            state        <= ACCEPT;
          end
        end
        default: begin
          mem_we   <= 1'b0;
          in_ready <= 1'b1;
          state    <= ACCEPT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_writer.sv
// Scoreboard bench for spectrum_writer: a bin-level model queues expected memory writes
// and finder results; a negedge monitor pops and compares whatever the DUT emits.
module tb_spectrum_writer;
  localparam int NB  = 512;
  localparam int IMO = 1024;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] in_re = '0;
  logic signed [15:0] in_im = '0;
  logic               in_last = 1'b0;
  logic [10:0]        mem_addr;
  logic signed [9:0]  mem_wdata;
  logic               mem_we;
  logic               find_enable;
  logic               find_done = 1'b0;
  logic [2:0]         find_note = '0;
  logic signed [9:0]  find_diff = '0;
  logic [2:0]         note_out;
  logic signed [9:0]  diff_out;
  logic               result_valid;
  logic               frame_err;

  spectrum_writer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .find_enable(find_enable), .find_done(find_done), .find_note(find_note),
    .find_diff(find_diff), .note_out(note_out), .diff_out(diff_out),
    .result_valid(result_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int note; int diff; } res_t;
  wr_t  wq[$];
  res_t rq[$];
  wr_t  mw;
  res_t mr;

  int total = 0, bad = 0;
  int exp_k = 0, exp_err = 0, exp_finds = 0, finds = 0, results = 0, exp_results = 0;
  int prev_we = 0, prev_addr = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Floor division by 64 followed by a clamp to the 10-bit signed range.
  function automatic int scale(input int v);
    int s;
    s = (v >= 0) ? v / 64 : -((-v + 63) / 64);
    if (s > 511) s = 511;
    if (s < -512) s = -512;
    return s;
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // Bin-level reference: each accepted bin yields two writes, then frame bookkeeping.
  task automatic model_bin(input int re, input int im, input bit last);
    wq.push_back('{exp_k, scale(re)});
    wq.push_back('{exp_k + IMO, scale(im)});
    if (last && exp_k == NB - 1) begin
      exp_k = 0;
      exp_finds++;
    end else if (!last && exp_k < NB - 1) begin
      exp_k++;
    end else begin
      exp_err = 1;
      exp_k = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", int'(mem_addr), -1);
        else begin
          mw = wq.pop_front();
          chk("wr_addr", int'(mem_addr), mw.addr);
          chk("wr_data", int'(mem_wdata), mw.data);
        end
      end
      if (find_enable) begin
        finds++;
        chk("find_after_last_wr_im", (prev_we == 1 && prev_addr == IMO + NB - 1) ? 1 : 0, 1);
      end
      if (result_valid) begin
        results++;
        if (rq.size() == 0) chk("unexpected_result", 1, 0);
        else begin
          mr = rq.pop_front();
          chk("note_out", int'(note_out), mr.note);
          chk("diff_out", int'(diff_out), mr.diff);
          chk("ready_with_result", int'(in_ready), 1);
        end
      end
    end
    prev_we   = int'(mem_we);
    prev_addr = int'(mem_addr);
  end

  task automatic send_bin(input int re, input int im, input bit last);
    int t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    in_last  = last;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_bin(re, im, last);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (wq.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("writes_drained", wq.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_find();
    int t = 0;
    while (finds < exp_finds && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("find_count", finds, exp_finds);
  endtask

  task automatic pulse_done(input int note, input int diff, input bit expect_it);
    @(negedge clk);
    find_done = 1'b1;
    find_note = 3'(note);
    find_diff = 10'(diff);
    if (expect_it) begin
      rq.push_back('{note, diff});
      exp_results++;
    end
    @(negedge clk);
    find_done = 1'b0;
    repeat (2) @(negedge clk);
    chk("result_count", results, exp_results);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    rq.delete();
    exp_k = 0;
    exp_err = 0;
  endtask

  task automatic rand_frame(input int nbins, input bit with_last);
    for (int i = 0; i < nbins; i++) begin
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send_bin(rnd16(), rnd16(), with_last && (i == nbins - 1));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_mem_we", int'(mem_we), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_mem_wdata", int'(mem_wdata), 0);
    chk("rst_find_enable", int'(find_enable), 0);
    chk("rst_note_out", int'(note_out), 0);
    chk("rst_diff_out", int'(diff_out), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    rst = 1'b0;

    // Ramp frame: re = k<<6, im = -(k<<6)
    for (int i = 0; i < NB; i++) send_bin(i * 64, -(i * 64), i == NB - 1);
    drain();
    wait_find();
    chk("frame_err_ramp", int'(frame_err), exp_err);
    repeat (3) @(negedge clk);
    chk("ready_low_wait_find", int'(in_ready), 0);
    pulse_done(3, -4, 1'b1);
    chk("note_held", int'(note_out), 3);
    chk("diff_held", int'(diff_out), -4);

    // Stray find_done while accepting must be ignored.
    pulse_done(5, 7, 1'b0);
    chk("note_unchanged", int'(note_out), 3);

    // Random frame with the saturation corners in the first bins.
    send_bin(32767, -32768, 1'b0);
    send_bin(-32768, 32767, 1'b0);
    send_bin(-1, -1, 1'b0);
    rand_frame(NB - 3, 1'b1);
    drain();
    wait_find();
    pulse_done(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)) - 512, 1'b1);

    // Early last on bin 10.
    for (int i = 0; i <= 10; i++) send_bin(rnd16(), rnd16(), i == 10);
    drain();
    chk("frame_err_early", int'(frame_err), exp_err);
    chk("no_find_early", finds, exp_finds);
    send_bin(rnd16(), rnd16(), 1'b0);
    drain();

    // Missing last on bin 511.
    do_reset();
    chk("frame_err_cleared", int'(frame_err), 0);
    rand_frame(NB, 1'b0);
    drain();
    chk("frame_err_missing", int'(frame_err), exp_err);
    chk("no_find_missing", finds, exp_finds);
    send_bin(rnd16(), rnd16(), 1'b0);
    drain();

    // Reset mid-frame at bin 200, then a clean frame.
    do_reset();
    rand_frame(200, 1'b0);
    drain();
    do_reset();
    rand_frame(NB, 1'b1);
    drain();
    wait_find();
    chk("frame_err_after_reset", int'(frame_err), 0);
    pulse_done(int'($urandom_range(0, 7)), int'($urandom_range(0, 1023)) - 512, 1'b1);

    // Reset while waiting for the finder abandons the handoff.
    rand_frame(NB, 1'b1);
    drain();
    wait_find();
    do_reset();
    send_bin(rnd16(), rnd16(), 1'b0);
    drain();
    chk("no_result_after_reset", results, exp_results);
    chk("find_total", finds, exp_finds);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
